// File: rtl/dnn_layer_sequencer.sv
// Per-layer handshake sequencer between the DMA and the DNN engine: gates the weights/pixels
// AXIS valid/ready per iteration, counts engine output packets and flags framing errors.
module dnn_layer_sequencer #(
    parameter int ITR_BITS  = 16,
    parameter int BEAT_BITS = 20
) (
    input  logic                 aclk,
    input  logic                 aresetn,

    input  logic                 desc_valid,
    output logic                 desc_ready,
    input  logic [ITR_BITS-1:0]  desc_itrs,
    input  logic [BEAT_BITS-1:0] desc_w_beats,
    input  logic [BEAT_BITS-1:0] desc_x_beats,

    input  logic                 s_w_valid,
    input  logic                 s_w_last,
    output logic                 s_w_ready,
    output logic                 m_w_valid,
    output logic                 m_w_last,
    input  logic                 m_w_ready,

    input  logic                 s_x_valid,
    input  logic                 s_x_last,
    output logic                 s_x_ready,
    output logic                 m_x_valid,
    output logic                 m_x_last,
    input  logic                 m_x_ready,

    input  logic                 o_valid,
    input  logic                 o_ready,
    input  logic                 o_last,

    output logic                 busy,
    output logic                 done,
    output logic [2:0]           err
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t               state, state_nxt;
    logic [ITR_BITS-1:0]  itrs_q, itr, out_cnt, out_cnt_nxt;
    logic [BEAT_BITS-1:0] w_beats_q, x_beats_q, w_cnt, x_cnt;

    logic accept, w_en, x_en, w_hs, x_hs, o_hs, out_sat, itr_end;
    logic w_final, x_final;

    // Gating is purely combinational so the data path sees no added latency.
    assign w_en      = (state == RUN) && (w_cnt != w_beats_q);
    assign x_en      = (state == RUN) && (x_cnt != x_beats_q);
    assign m_w_valid = s_w_valid & w_en;
    assign s_w_ready = m_w_ready & w_en;
    assign m_w_last  = s_w_last;
    assign m_x_valid = s_x_valid & x_en;
    assign s_x_ready = m_x_ready & x_en;
    assign m_x_last  = s_x_last;

    assign w_hs    = m_w_valid & m_w_ready;
    assign x_hs    = m_x_valid & m_x_ready;
    assign w_final = (w_cnt == w_beats_q - BEAT_BITS'(1));
    assign x_final = (x_cnt == x_beats_q - BEAT_BITS'(1));

    // Both streams complete on the registered counts; this cycle is the iteration bubble.
    assign itr_end = (state == RUN) && (w_cnt == w_beats_q) && (x_cnt == x_beats_q);

    assign o_hs        = o_valid & o_ready & o_last & ((state == RUN) || (state == DRAIN));
    assign out_sat     = (out_cnt == itrs_q);
    assign out_cnt_nxt = (o_hs && !out_sat) ? out_cnt + ITR_BITS'(1) : out_cnt;

    assign desc_ready = (state == IDLE);
    assign accept     = desc_valid & desc_ready;
    assign busy       = (state != IDLE);
    assign done       = (state == DONE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = (desc_itrs == '0) ? DRAIN : RUN;
            RUN:     if (itr_end && (itr + ITR_BITS'(1) == itrs_q)) state_nxt = DRAIN;
            DRAIN:   if (out_cnt_nxt == itrs_q) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state <= IDLE;
        else          state <= state_nxt;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            itrs_q    <= '0;
            w_beats_q <= '0;
            x_beats_q <= '0;
            itr       <= '0;
            w_cnt     <= '0;
            x_cnt     <= '0;
            out_cnt   <= '0;
            err       <= '0;
        end else if (accept) begin
            itrs_q    <= desc_itrs;
            w_beats_q <= desc_w_beats;
            x_beats_q <= desc_x_beats;
            itr       <= '0;
            w_cnt     <= '0;
            x_cnt     <= '0;
            out_cnt   <= '0;
            err       <= '0;
        end else begin
            if (itr_end) begin
                w_cnt <= '0;
                x_cnt <= '0;
                itr   <= itr + ITR_BITS'(1);
            end else begin
                if (w_hs) w_cnt <= w_cnt + BEAT_BITS'(1);
                if (x_hs) x_cnt <= x_cnt + BEAT_BITS'(1);
            end
            out_cnt <= out_cnt_nxt;
            // Framing errors only flag; beats are still forwarded.
            if (w_hs && (s_w_last != w_final)) err[0] <= 1'b1;
            if (x_hs && (s_x_last != x_final)) err[1] <= 1'b1;
            if (o_hs && out_sat)               err[2] <= 1'b1;
        end
    end

endmodule
